// File: rtl/sprom_burst_pkg.sv
// rtl/sprom_burst_pkg.sv - shared types for the ROM burst arbiter
//
// Purpose: FSM state encoding and the per-issue tag that travels alongside
// each ROM read so the response stage knows which requester and which word
// of the burst the returning data belongs to.
// Ports: none (package).

package sprom_burst_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Widest requester index supported (NREQ up to 16). Modules derive their
  // own IDW = $clog2(NREQ) and use only the low IDW bits of tag_t.id.
  localparam int IDW_MAX = 4;

  typedef struct packed {
    logic               vld;
    logic [IDW_MAX-1:0] id;
    logic               last;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered priority pointer
//
// Purpose: one-hot grant among req, searching from last_grant+1 and
// wrapping. The pointer is loaded from last_grant when update is high.
// Ports:
//   clk, rst_n   clock, async active-low reset (pointer -> N-1, so req 0 wins first)
//   req          request vector
//   last_grant   index of the requester just served
//   update       strobe: record last_grant as the new pointer
//   grant        one-hot grant (combinational), zero when no request

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  input  logic                 update,
  output logic [N-1:0]         grant
);

  localparam int W = $clog2(N);

  logic [W-1:0] ptr;
  logic [W-1:0] idx;
  logic         found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= W'(N - 1);
    end else if (update) begin
      ptr <= last_grant;
    end
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprom_burst_arbiter.sv
// rtl/sprom_burst_arbiter.sv - shares one single-port ROM among burst requesters
//
// Purpose: round-robin accept of burst requests, one ROM address issued per
// cycle, read data returned on a tagged response stream (no backpressure).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot, IDLE only)
//   req_addr, req_len      packed start address and burst length-1 per requester
//   rom_addr, rom_q        ROM address out, ROM data in (RD_LATENCY cycles later)
//   rsp_valid/data/id/last response word, requester index, final-word flag
//   busy                   burst in progress or responses still in flight

module sprom_burst_arbiter
  import sprom_burst_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int AWIDTH     = 8,
  parameter int DWIDTH     = 128,
  parameter int LWIDTH     = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*LWIDTH-1:0]   req_len,
  output logic [AWIDTH-1:0]        rom_addr,
  input  logic [DWIDTH-1:0]        rom_q,
  output logic                     rsp_valid,
  output logic [DWIDTH-1:0]        rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_last,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);

  state_t             state, state_nxt;
  logic [AWIDTH-1:0]  cur_addr;
  logic [AWIDTH-1:0]  sel_addr;
  logic [LWIDTH-1:0]  remaining;
  logic [LWIDTH-1:0]  sel_len;
  logic [IDW-1:0]     gid;
  logic [IDW-1:0]     win_id;
  logic [NREQ-1:0]    grant;
  logic               accept;
  logic               last_issue;
  tag_t               cur_tag;
  tag_t               tag_out;
  logic               pipe_any;
  logic [IDW_MAX-1:0] tag_id_unused;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_valid),
    .last_grant (win_id),
    .update     (accept),
    .grant      (grant)
  );

  // Ready is gated by rst_n so it reads 0 while reset is held.
  always_comb begin
    req_ready = (rst_n && state == IDLE) ? grant : '0;
    accept    = |(req_ready & req_valid);
    sel_addr  = '0;
    sel_len   = '0;
    win_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*AWIDTH +: AWIDTH];
        sel_len  = req_len[i*LWIDTH +: LWIDTH];
        win_id   = IDW'(i);
      end
    end
  end

  assign last_issue = (state == BURST) && (remaining == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = BURST;
      BURST:   if (last_issue) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // The first address is driven straight from the accept so it appears in
  // the cycle after accept; cur_addr therefore holds the *next* address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      gid       <= '0;
    end else if (state == IDLE && accept) begin
      rom_addr  <= sel_addr;
      cur_addr  <= sel_addr + AWIDTH'(1);
      remaining <= sel_len;
      gid       <= win_id;
    end else if (state == BURST && !last_issue) begin
      rom_addr  <= cur_addr;
      cur_addr  <= cur_addr + AWIDTH'(1);
      remaining <= remaining - LWIDTH'(1);
    end
  end

  // Tag for the address on rom_addr this cycle; all-zero when nothing issues.
  always_comb begin
    cur_tag              = '0;
    cur_tag.vld          = (state == BURST);
    cur_tag.id[IDW-1:0]  = gid;
    cur_tag.last         = last_issue;
  end

  generate
    if (RD_LATENCY == 0) begin : g_no_pipe
      assign tag_out  = cur_tag;
      assign pipe_any = 1'b0;
    end else begin : g_pipe
      tag_t pipe [RD_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= cur_tag;
          for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end

      always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) pipe_any = pipe_any | pipe[i].vld;
      end

      assign tag_out = pipe[RD_LATENCY-1];
    end
  endgenerate

  // Upper id bits exist only to fit the widest NREQ; they are always zero.
  assign tag_id_unused = tag_out.id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
    end else begin
      rsp_valid <= tag_out.vld;
      if (tag_out.vld) rsp_data <= rom_q;
      rsp_id    <= tag_out.vld ? tag_out.id[IDW-1:0] : '0;
      rsp_last  <= tag_out.vld & tag_out.last;
    end
  end

  assign busy = (state == BURST) | pipe_any | rsp_valid;

endmodule

// File: tb/tb_sprom_burst_arbiter.sv
// tb/tb_sprom_burst_arbiter.sv - directed self-checking bench for sprom_burst_arbiter

module tb_sprom_burst_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 128;
  localparam int LW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;

  logic [NREQ-1:0]   req_ready1, req_ready0;
  logic [AW-1:0]     rom_addr1, rom_addr0;
  logic [DW-1:0]     rom_q1, rom_q0;
  logic              rsp_valid1, rsp_valid0;
  logic [DW-1:0]     rsp_data1, rsp_data0;
  logic [1:0]        rsp_id1, rsp_id0;
  logic              rsp_last1, rsp_last0;
  logic              busy1, busy0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprom_burst_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_addr(req_addr), .req_len(req_len), .rom_addr(rom_addr1), .rom_q(rom_q1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_id(rsp_id1),
    .rsp_last(rsp_last1), .busy(busy1)
  );

  sprom_burst_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW), .RD_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_addr(req_addr), .req_len(req_len), .rom_addr(rom_addr0), .rom_q(rom_q0),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_id(rsp_id0),
    .rsp_last(rsp_last0), .busy(busy0)
  );

  // ROM contents: ROM[k] = k. Registered read for dut1, combinational for dut0.
  always @(posedge clk) rom_q1 <= DW'(rom_addr1);
  assign rom_q0 = DW'(rom_addr0);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [3:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
  endtask

  // Called in the accept cycle T. Walks T+1..T+len+4 checking both DUTs.
  task automatic check_burst(input logic [7:0] a, input int len, input int id,
                             input logic [3:0] keep_valid, input logic [3:0] next_ready);
    logic [7:0] e;
    logic       v;
    for (int c = 1; c <= len + 4; c++) begin
      tick();
      if (c == 1) req_valid = keep_valid;
      if (c <= len + 1) begin
        e = a + 8'(c - 1);
        chk("burst_ready1", 128'(req_ready1), 128'(0));
        chk("burst_ready0", 128'(req_ready0), 128'(0));
        chk("rom_addr1", 128'(rom_addr1), 128'(e));
      end
      if (c == len + 2) begin
        chk("next_ready1", 128'(req_ready1), 128'(next_ready));
        chk("next_ready0", 128'(req_ready0), 128'(next_ready));
        req_valid = '0;
      end
      // RD_LATENCY=1: words in T+3..T+len+3
      v = (c >= 3) && (c <= len + 3);
      chk("rsp_valid1", 128'(rsp_valid1), 128'(v));
      if (v) begin
        e = a + 8'(c - 3);
        chk("rsp_data1", 128'(rsp_data1), 128'(e));
        chk("rsp_id1", 128'(rsp_id1), 128'(id));
        chk("rsp_last1", 128'(rsp_last1), 128'(c == len + 3));
      end else begin
        chk("rsp_id1_idle", 128'(rsp_id1), 128'(0));
        chk("rsp_last1_idle", 128'(rsp_last1), 128'(0));
      end
      chk("busy1", 128'(busy1), 128'(c <= len + 3));
      // RD_LATENCY=0: words in T+2..T+len+2
      v = (c >= 2) && (c <= len + 2);
      chk("rsp_valid0", 128'(rsp_valid0), 128'(v));
      if (v) begin
        e = a + 8'(c - 2);
        chk("rsp_data0", 128'(rsp_data0), 128'(e));
        chk("rsp_id0", 128'(rsp_id0), 128'(id));
        chk("rsp_last0", 128'(rsp_last0), 128'(c == len + 2));
      end
      chk("busy0", 128'(busy0), 128'(c <= len + 2));
    end
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;

    // Reset state, with a request already pending
    set_req(2, 8'h10, 4'd3);
    req_valid = 4'b0100;
    tick();
    tick();
    chk("rst_ready1", 128'(req_ready1), 128'(0));
    chk("rst_rsp_valid1", 128'(rsp_valid1), 128'(0));
    chk("rst_busy1", 128'(busy1), 128'(0));
    chk("rst_rom_addr1", 128'(rom_addr1), 128'(0));
    chk("rst_rsp_data1", 128'(rsp_data1), 128'(0));

    // Single burst: requester 2, addr 0x10, len 3
    rst_n = 1'b1;
    #1;
    chk("s1_ready1", 128'(req_ready1), 128'(4'b0100));
    chk("s1_ready0", 128'(req_ready0), 128'(4'b0100));
    check_burst(8'h10, 3, 2, 4'b0000, 4'b0000);

    // Address wrap: requester 1, addr 0xFE, len 3 -> FE FF 00 01
    set_req(1, 8'hFE, 4'd3);
    req_valid = 4'b0010;
    #1;
    chk("s2_ready1", 128'(req_ready1), 128'(4'b0010));
    check_burst(8'hFE, 3, 1, 4'b0000, 4'b0000);

    // Max length: requester 3 len 15 wins over 0 (pointer at 1); 0 waits
    set_req(3, 8'h40, 4'd15);
    set_req(0, 8'h00, 4'd0);
    req_valid = 4'b1001;
    #1;
    chk("s5_ready1", 128'(req_ready1), 128'(4'b1000));
    check_burst(8'h40, 15, 3, 4'b0001, 4'b0001);

    // Round robin, all valid, len 0: grants 0,1,2,3,0 every other cycle
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h20 + i), 4'd0);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_ready1", 128'(req_ready1), 128'(1) << order[k]);
      tick();
      chk("rr_rom_addr1", 128'(rom_addr1), 128'(8'h20 + order[k]));
      chk("rr_gap_ready1", 128'(req_ready1), 128'(0));
      if (k > 0) begin
        chk("rr_rsp_valid1", 128'(rsp_valid1), 128'(1));
        chk("rr_rsp_id1", 128'(rsp_id1), 128'(order[k-1]));
        chk("rr_rsp_data1", 128'(rsp_data1), 128'(8'h20 + order[k-1]));
        chk("rr_rsp_last1", 128'(rsp_last1), 128'(1));
      end
      tick();
      chk("rr_idle_rsp1", 128'(rsp_valid1), 128'(0));
      chk("rr_rsp_valid0", 128'(rsp_valid0), 128'(1));
      chk("rr_rsp_id0", 128'(rsp_id0), 128'(order[k]));
      if (k == 4) req_valid = '0;
    end
    tick();
    chk("rr_tail_valid1", 128'(rsp_valid1), 128'(1));
    chk("rr_tail_id1", 128'(rsp_id1), 128'(0));
    tick();
    tick();
    chk("rr_drained_busy1", 128'(busy1), 128'(0));

    // Reset during the third issue cycle of a len-7 burst from requester 2
    set_req(2, 8'h80, 4'd7);
    req_valid = 4'b0100;
    #1;
    chk("s6_ready1", 128'(req_ready1), 128'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("s6_rom_addr1", 128'(rom_addr1), 128'(8'h82));
    chk("s6_rsp_valid1", 128'(rsp_valid1), 128'(1));
    chk("s6_rsp_data1", 128'(rsp_data1), 128'(8'h80));
    rst_n = 1'b0;
    set_req(0, 8'h05, 4'd0);
    set_req(3, 8'h33, 4'd1);
    req_valid = 4'b1001;
    #1;
    chk("s6_rst_rom_addr1", 128'(rom_addr1), 128'(0));
    chk("s6_rst_rsp_valid1", 128'(rsp_valid1), 128'(0));
    chk("s6_rst_rsp_data1", 128'(rsp_data1), 128'(0));
    chk("s6_rst_rsp_id1", 128'(rsp_id1), 128'(0));
    chk("s6_rst_rsp_last1", 128'(rsp_last1), 128'(0));
    chk("s6_rst_busy1", 128'(busy1), 128'(0));
    chk("s6_rst_ready1", 128'(req_ready1), 128'(0));
    chk("s6_rst_busy0", 128'(busy0), 128'(0));
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("s6_hold_rsp_valid1", 128'(rsp_valid1), 128'(0));
      chk("s6_hold_rsp_valid0", 128'(rsp_valid0), 128'(0));
      chk("s6_hold_busy1", 128'(busy1), 128'(0));
    end
    rst_n = 1'b1;
    #1;
    chk("s6_after_ready1", 128'(req_ready1), 128'(4'b0001));
    chk("s6_after_ready0", 128'(req_ready0), 128'(4'b0001));
    check_burst(8'h05, 0, 0, 4'b1000, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprom_burst_arbiter.md
Name: sprom_burst_arbiter

Overview:
- Shares one single-port ROM (sprom-style: synchronous or combinational read) between NREQ requesters.
- Each requester asks for a burst of consecutive ROM words. Requests are granted round-robin. Each granted burst is issued one address per cycle.
- Read data is returned on a shared, tagged response stream.
- Sits between table-lookup clients (coefficient/microcode fetchers) and the ROM instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- AWIDTH, 8, ROM address width; ROM depth = 2^AWIDTH.
- DWIDTH, 128, ROM data width.
- LWIDTH, 4, burst length field width; burst length = req_len+1 (1..2^LWIDTH).
- RD_LATENCY, 1, ROM read latency in cycles: 1 for registered output, 0 for combinational.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_addr  in  NREQ*AWIDTH  packed start addresses, requester i at [i*AWIDTH +: AWIDTH]
- req_len  in  NREQ*LWIDTH  packed burst length-1
- rom_addr  out  AWIDTH  address to ROM
- rom_q  in  DWIDTH  ROM read data
- rsp_valid  out  1  response word valid
- rsp_data  out  DWIDTH  response word
- rsp_id  out  $clog2(NREQ)  requester index of the word
- rsp_last  out  1  final word of the burst
- busy  out  1  burst in progress or responses in flight

Behaviour:
- Reset (async assert, sync-safe deassert) drives the following to 0: state=IDLE, req_ready, rom_addr, rsp_valid, rsp_data, rsp_id, rsp_last, busy, tag pipeline, remaining-count. The round-robin pointer resets so requester 0 has highest priority.
- FSM states are IDLE and BURST.
- IDLE:
  - req_ready is combinational and one-hot, for the round-robin winner among req_valid. The search starts at last_grant+1 and wraps.
  - If no requester is valid, req_ready=0.
  - Accept occurs when req_valid[i] & req_ready[i]. On accept:
    - cur_addr <= req_addr[i]
    - remaining <= req_len[i]
    - gid <= i
    - last_grant <= i
    - state <= BURST
- BURST:
  - req_ready=0 throughout.
  - rom_addr = cur_addr, registered. Exactly one issue per cycle.
  - cur_addr increments modulo 2^AWIDTH, so address 2^AWIDTH-1 wraps to 0.
  - remaining decrements each cycle.
  - The issue cycle with remaining==0 is marked last; the next state is IDLE.
  - At least one IDLE cycle separates consecutive bursts.
- Requester behaviour: a requester may drop req_valid before it is accepted, with no side effect. req_addr and req_len are sampled only in the accept cycle.
- Tag pipeline:
  - Each issue pushes {1, gid, last} into a RD_LATENCY-deep shift register. Non-issue cycles push zeros.
  - At the pipeline output, rom_q is valid for that tag.
  - The response stage registers rsp_valid, rsp_data=rom_q, rsp_id and rsp_last from the tag output.
  - When RD_LATENCY=0, the tag pipeline is a wire.
- Latency:
  - Accept at cycle T → first rom_addr in cycle T+1 → first rsp_valid in cycle T+2+RD_LATENCY.
  - Subsequent words follow every cycle, with no gaps, for exactly len+1 words.
- Response stream: no backpressure; consumers must accept every word. When rsp_valid=0, rsp_data holds its last value; rsp_id and rsp_last are 0.
- busy = (state==BURST) | any tag valid | rsp_valid.
- Reset mid-burst: immediate abort and all state cleared. In-flight responses are discarded. The first cycle after release is IDLE with requester 0 prioritised.
- Rules for undriven fields: rom_addr holds its last value while IDLE. The ROM is read every cycle, but unissued reads carry no tag.

Decomposition:
- Package sprom_burst_pkg:
  - state enum typedef (IDLE, BURST).
  - tag struct typedef {vld, id, last}.
  - localparam IDW = $clog2(NREQ) (parameterised via module localparam).
- Sub-module rr_arbiter #(N): inputs req[N], last_grant and an update strobe; output grant[N], one-hot. It is reusable elsewhere.
- The tag shift register stays inline.

Test Plan:
- Single request, RD_LATENCY=1, ROM[k]=k:
  - Stimulus: requester 2, addr=0x10, len=3, accepted at cycle T.
  - Response: rsp_valid in cycles T+3..T+6; data 0x10..0x13; rsp_id=2 on all words; rsp_last only at T+6; busy drops at T+7.
- Wrap-around:
  - Stimulus: addr=0xFE, len=3.
  - Response: data sequence 0xFE, 0xFF, 0x00, 0x01.
- Round-robin with all four requesters valid continuously, len=0 each:
  - Grant order is 0, 1, 2, 3, 0; each accept is separated by the one-cycle IDLE gap.
  - rsp_id follows the same order.
- RD_LATENCY=0 variant:
  - Stimulus: same as the first scenario.
  - Response: first rsp_valid at T+2; data identical.
- Maximum length:
  - Stimulus: len=15.
  - Response: 16 contiguous words; other requesters see no req_ready until the cycle after the last issue.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 during the third issue cycle.
  - Response: all outputs go to 0 immediately, with no further rsp_valid. After release with requesters 0 and 3 valid, requester 0 is granted first.
